// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O display path: seven-segment
// codes (active-low, bit order g,f,e,d,c,b,a), anode constants and a small
// helper that turns a scan index into an active-low anode select.
package io_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] AN_OFF = 4'b1111;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low one-hot anode pattern for scan index idx (0 = rightmost).
    function automatic logic [3:0] an_select(input logic [1:0] idx);
        an_select = ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex7seg
    import io_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Map each hex value onto its segment pattern.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Four-digit multiplexed seven-segment scanner for common-anode displays.
// The displayed value is shadowed once per frame (at the digit 3 -> 0
// boundary) so a CPU write mid-frame never produces a torn image. Each
// digit slot starts with a short dark guard interval to suppress ghosting
// while the anode and segment drivers change over.
module hex_display_scanner
    import io_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] display_data,
    input  logic                  display_en,
    input  logic                  lz_blank,
    output logic [3:0]            an,
    output logic [6:0]            seg,
    output logic                  frame_tick
);

    localparam int              CNT_W     = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);

    // Catch illegal parameterisations at elaboration rather than in silicon.
    if (DATA_WIDTH != 4 * NUM_DIGITS) begin : g_bad_width
        $error("hex_display_scanner: DATA_WIDTH must be %0d", 4 * NUM_DIGITS);
    end
    if (GUARD < 1) begin : g_bad_guard
        $error("hex_display_scanner: GUARD must be at least 1");
    end
    if (REFRESH_DIV < GUARD + 2) begin : g_bad_div
        $error("hex_display_scanner: REFRESH_DIV must be at least GUARD+2");
    end

    logic [CNT_W-1:0]      cnt;
    logic [1:0]            digit;
    logic [DATA_WIDTH-1:0] shadow;

    logic       slot_end;
    logic       frame_end;
    logic [3:0] nibble;
    logic [3:0] nib_zero;
    logic [3:0] blank;
    logic       lit;
    logic [6:0] seg_code;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (digit == 2'd3);

    // Select the nibble belonging to the digit currently being scanned.
    always_comb begin
        nibble = shadow[3:0];
        case (digit)
            2'd0: nibble = shadow[3:0];
            2'd1: nibble = shadow[7:4];
            2'd2: nibble = shadow[11:8];
            2'd3: nibble = shadow[15:12];
        endcase
    end

    // Leading-zero suppression: a digit is blank when it and every digit to
    // its left are zero. The rightmost digit always shows, so 0 reads "0".
    always_comb begin
        nib_zero[0] = (shadow[3:0]   == 4'h0);
        nib_zero[1] = (shadow[7:4]   == 4'h0);
        nib_zero[2] = (shadow[11:8]  == 4'h0);
        nib_zero[3] = (shadow[15:12] == 4'h0);
        blank[3]    = lz_blank && nib_zero[3];
        blank[2]    = blank[3] && nib_zero[2];
        blank[1]    = blank[2] && nib_zero[1];
        blank[0]    = 1'b0;
    end

    // Anode is driven only outside the guard window, when enabled and unblanked.
    always_comb begin
        lit = (cnt >= CNT_GUARD) && display_en && !blank[digit];
    end

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg_code)
    );

    // Slot counter and scan index; the scan runs regardless of display_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            digit <= 2'd0;
        end else if (slot_end) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Frame-synchronous shadow: only the value present in the boundary cycle is captured.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (frame_end) begin
            shadow <= display_data;
        end
    end

    // Registered drivers so the pads see glitch-free anode/segment changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= lit ? an_select(digit) : AN_OFF;
            seg        <= lit ? seg_code : SEG_OFF;
            frame_tick <= frame_end;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with REFRESH_DIV=8, GUARD=2.
// Outputs are sampled on the falling edge; after the k-th rising edge since
// reset release they reflect the scanner state of cycle k-1.
module tb_hex_display_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] display_data;
    logic        display_en;
    logic        lz_blank;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hex_display_scanner #(
        .DATA_WIDTH  (16),
        .REFRESH_DIV (8),
        .GUARD       (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .display_data (display_data),
        .display_en   (display_en),
        .lz_blank     (lz_blank),
        .an           (an),
        .seg          (seg),
        .frame_tick   (frame_tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One 8-cycle digit slot: 2 dark guard cycles, then exp_an/exp_seg.
    // display_data is changed to chg_val during slot cycle chg_at (-1 = never).
    task automatic run_slot(input string tag, input logic [1:0] dig,
                            input logic [3:0] exp_an, input logic [6:0] exp_seg,
                            input int chg_at, input logic [15:0] chg_val);
        for (int i = 0; i < 8; i++) begin
            if (i == chg_at) display_data = chg_val;
            tick();
            if (i < 2) begin
                chk({tag, " guard an"}, an, 4'b1111);
                chk({tag, " guard seg"}, seg, 7'h7F);
            end else begin
                chk({tag, " an"}, an, exp_an);
                chk({tag, " seg"}, seg, exp_seg);
            end
            chk({tag, " frame_tick"}, frame_tick, (dig == 2'd3) && (i == 7));
        end
    endtask

    logic [3:0] an_tab [4];

    initial begin
        an_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        reset_n      = 1'b0;
        display_data = 16'h0000;
        display_en   = 1'b1;
        lz_blank     = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Run into the lit part of slot 0, then assert reset asynchronously.
        repeat (5) tick();
        chk("pre-reset an", an, 4'b1110);
        chk("pre-reset seg", seg, 7'h40);
        #3 reset_n = 1'b0;
        #1;
        chk("async reset an", an, 4'b1111);
        chk("async reset seg", seg, 7'h7F);
        chk("async reset frame_tick", frame_tick, 1'b0);

        display_data = 16'h1234;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Frame 1: shadow still 0000 after reset.
        run_slot("f1 d0", 2'd0, 4'b1110, 7'h40, -1, 16'h0);
        run_slot("f1 d1", 2'd1, 4'b1101, 7'h40, -1, 16'h0);
        run_slot("f1 d2", 2'd2, 4'b1011, 7'h40, -1, 16'h0);
        run_slot("f1 d3", 2'd3, 4'b0111, 7'h40, -1, 16'h0);

        // Frame 2: 1234 captured at cycle 31.
        run_slot("f2 d0", 2'd0, 4'b1110, 7'h19, -1, 16'h0);
        run_slot("f2 d1", 2'd1, 4'b1101, 7'h30, -1, 16'h0);
        run_slot("f2 d2", 2'd2, 4'b1011, 7'h24, -1, 16'h0);
        run_slot("f2 d3", 2'd3, 4'b0111, 7'h79, -1, 16'h0);

        // Frame 3: mid-frame write is hidden; boundary-cycle write of ABCD wins.
        run_slot("f3 d0", 2'd0, 4'b1110, 7'h19, -1, 16'h0);
        run_slot("f3 d1", 2'd1, 4'b1101, 7'h30, 3, 16'hFFFF);
        run_slot("f3 d2", 2'd2, 4'b1011, 7'h24, -1, 16'h0);
        run_slot("f3 d3", 2'd3, 4'b0111, 7'h79, 7, 16'hABCD);

        // Frame 4: ABCD; the write right after the boundary must not show.
        lz_blank = 1'b1;
        run_slot("f4 d0", 2'd0, 4'b1110, 7'h21, 0, 16'h0050);
        run_slot("f4 d1", 2'd1, 4'b1101, 7'h46, -1, 16'h0);
        run_slot("f4 d2", 2'd2, 4'b1011, 7'h03, -1, 16'h0);
        run_slot("f4 d3", 2'd3, 4'b0111, 7'h08, -1, 16'h0);

        // Frame 5: 0050 with leading-zero blanking.
        run_slot("f5 d0", 2'd0, 4'b1110, 7'h40, 0, 16'h0000);
        run_slot("f5 d1", 2'd1, 4'b1101, 7'h12, -1, 16'h0);
        run_slot("f5 d2", 2'd2, 4'b1111, 7'h7F, -1, 16'h0);
        run_slot("f5 d3", 2'd3, 4'b1111, 7'h7F, -1, 16'h0);

        // Frame 6: 0000 with blanking leaves only digit 0 lit.
        run_slot("f6 d0", 2'd0, 4'b1110, 7'h40, -1, 16'h0);
        run_slot("f6 d1", 2'd1, 4'b1111, 7'h7F, -1, 16'h0);
        run_slot("f6 d2", 2'd2, 4'b1111, 7'h7F, -1, 16'h0);
        run_slot("f6 d3", 2'd3, 4'b1111, 7'h7F, -1, 16'h0);

        // Frame 7: display off for 20 cycles, scan and frame_tick keep going.
        display_en = 1'b0;
        lz_blank   = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 20) display_en = 1'b1;
            tick();
            if (i < 20 || (i % 8) < 2) begin
                chk("f7 dark an", an, 4'b1111);
                chk("f7 dark seg", seg, 7'h7F);
            end else begin
                chk("f7 an", an, an_tab[i / 8]);
                chk("f7 seg", seg, 7'h40);
            end
            chk("f7 frame_tick", frame_tick, i == 31);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
